// File: rtl/rom_dl_sched.sv
// rom_dl_sched: turns the data_io ROM download byte stream into SDRAM word
// writes for the Alpha68k core. It strips the board header (pcb/brd/tate),
// packs payload bytes into 16-bit words, queues them in a small FIFO and
// drains them over a req/ack write port. rom_loaded rises once the download
// has ended and every queued write has been accepted.
//
// Optional feature: define DL_CHECKSUM_EN to build the payload checksum on csum;
// when it is undefined, csum is tied to zero.
//
// Write-port handshake: wr_req is high exactly while the FIFO holds at least one
// entry. wr_addr/wr_data/wr_be show the head entry and hold steady until the
// cycle in which wr_ack is high. That ack pops the head, and the next entry
// appears on the following cycle. An ack while wr_req is low does nothing.
module rom_dl_sched #(
    parameter int HDR_BYTES  = 2,
    parameter int AW         = 23,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk_72,
    input  logic          reset,
    input  logic          ioctl_downl,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic [3:0]    pcb,
    output logic          tate,
    output logic [7:0]    brd,
    output logic          wr_req,
    input  logic          wr_ack,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   wr_data,
    output logic [1:0]    wr_be,
    output logic          rom_loaded,
    output logic          busy,
    output logic          overflow,
    output logic [15:0]   csum,
    output logic [1:0]    dbg_state
);

    localparam int         PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [24:0] HDR_A    = 25'(HDR_BYTES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic [1:0]    be;
    } entry_t;

    state_t        state_q, state_d;
    logic          downl_q, downl_d;
    logic          rise, fall;
    logic          load_entry;
    logic          rom_loaded_o, busy_o;

    logic [3:0]    pcb_q, pcb_d;
    logic          tate_q, tate_d;
    logic [7:0]    brd_q, brd_d;

    logic [7:0]    half_q, half_d;
    logic [AW-1:0] half_addr_q, half_addr_d;
    logic          half_valid_q, half_valid_d;
    logic          overflow_q, overflow_d;

    entry_t        mem_q [FIFO_DEPTH];
    entry_t        mem_d [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]   count_q, count_d;

    logic          in_load, hdr_hit, pay_hit;
    logic [24:0]   p;
    logic [AW-1:0] waddr;
    logic          push, do_push, pop;
    entry_t        push_entry;
    entry_t        head;

    assign rise = ioctl_downl & ~downl_q;
    assign fall = ~ioctl_downl & downl_q;

    // FSM state register and download-strobe history
    always_ff @(posedge clk_72) begin
        if (reset) begin
            state_q <= S_IDLE;
            downl_q <= 1'b0;
        end else begin
            state_q <= state_d;
            downl_q <= downl_d;
        end
    end

    // FSM next-state: download edges move between phases, FLUSH waits for drain
    always_comb begin
        state_d = state_q;
        downl_d = ioctl_downl;
        case (state_q)
            S_IDLE:  if (rise) state_d = S_LOAD;
            S_LOAD:  if (fall) state_d = S_FLUSH;
            S_FLUSH: if (count_q == '0 && !half_valid_q) state_d = S_DONE;
            S_DONE:  if (rise) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: status flags and the one-cycle LOAD entry strobe
    always_comb begin
        rom_loaded_o = (state_q == S_DONE);
        busy_o       = (state_q == S_LOAD) || (state_q == S_FLUSH);
        load_entry   = rise && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    // Byte decode, half-word packing, FIFO pointer/count and overflow update
    always_comb begin
        pcb_d        = pcb_q;
        tate_d       = tate_q;
        brd_d        = brd_q;
        half_d       = half_q;
        half_addr_d  = half_addr_q;
        half_valid_d = half_valid_q;
        overflow_d   = overflow_q;
        mem_d        = mem_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        push         = 1'b0;
        push_entry   = '0;

        in_load = (state_q == S_LOAD);
        p       = ioctl_addr - HDR_A;
        waddr   = p[AW:1];
        hdr_hit = in_load && ioctl_wr && (ioctl_addr < HDR_A);
        // Addresses past the SDRAM word range are silently discarded
        pay_hit = in_load && ioctl_wr && (ioctl_addr >= HDR_A) && ((p >> (AW + 1)) == '0);

        if (hdr_hit) begin
            if (ioctl_addr == 25'd0) begin
                tate_d = ioctl_dout[7];
                pcb_d  = ioctl_dout[3:0];
            end
            if (ioctl_addr == 25'd1) begin
                brd_d = ioctl_dout;
            end
        end

        if (load_entry) begin
            half_valid_d = 1'b0;
            overflow_d   = 1'b0;
        end else if (pay_hit) begin
            if (!p[0]) begin
                // A low byte still waiting has lost its partner: write it alone
                if (half_valid_q) begin
                    push       = 1'b1;
                    push_entry = '{addr: half_addr_q, data: {8'h00, half_q}, be: 2'b01};
                end
                half_d       = ioctl_dout;
                half_addr_d  = waddr;
                half_valid_d = 1'b1;
            end else begin
                push         = 1'b1;
                push_entry   = '{addr: waddr,
                                 data: {ioctl_dout, half_valid_q ? half_q : 8'h00},
                                 be:   half_valid_q ? 2'b11 : 2'b10};
                half_valid_d = 1'b0;
            end
        end else if (state_q == S_FLUSH && half_valid_q) begin
            push         = 1'b1;
            push_entry   = '{addr: half_addr_q, data: {8'h00, half_q}, be: 2'b01};
            half_valid_d = 1'b0;
        end

        pop     = wr_ack && (count_q != '0);
        do_push = push && ((count_q != CNT_FULL) || pop);
        if (push && !do_push) begin
            overflow_d = 1'b1;
        end
        if (do_push) begin
            mem_d[wptr_q] = push_entry;
            wptr_d        = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        count_d = count_q + (PW+1)'(do_push) - (PW+1)'(pop);
    end

    // Control, header and FIFO bookkeeping registers
    always_ff @(posedge clk_72) begin
        if (reset) begin
            pcb_q        <= '0;
            tate_q       <= 1'b0;
            brd_q        <= '0;
            half_q       <= '0;
            half_addr_q  <= '0;
            half_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
        end else begin
            pcb_q        <= pcb_d;
            tate_q       <= tate_d;
            brd_q        <= brd_d;
            half_q       <= half_d;
            half_addr_q  <= half_addr_d;
            half_valid_q <= half_valid_d;
            overflow_q   <= overflow_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage; contents are don't-care while the matching slot is empty
    always_ff @(posedge clk_72) begin
        mem_q <= mem_d;
    end

`ifdef DL_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    // Running payload byte sum, restarted on each new download
    always_comb begin
        csum_d = csum_q;
        if (load_entry) begin
            csum_d = '0;
        end else if (pay_hit) begin
            csum_d = csum_q + {8'h00, ioctl_dout};
        end
    end

    // Checksum register
    always_ff @(posedge clk_72) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;
`else
    assign csum = 16'h0000;
`endif

    // Head of the FIFO drives the write port; outputs read zero while empty
    assign head       = mem_q[rptr_q];
    assign wr_req     = (count_q != '0);
    assign wr_addr    = wr_req ? head.addr : '0;
    assign wr_data    = wr_req ? head.data : '0;
    assign wr_be      = wr_req ? head.be   : '0;
    assign pcb        = pcb_q;
    assign tate       = tate_q;
    assign brd        = brd_q;
    assign overflow   = overflow_q;
    assign rom_loaded = rom_loaded_o;
    assign busy       = busy_o;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_rom_dl_sched.sv
// tb_rom_dl_sched: directed bench for rom_dl_sched. Every write seen on the
// SDRAM port is compared against an expected queue of hand-computed words.
module tb_rom_dl_sched;

  localparam int AW = 23;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam int EW = AW + 16 + 2;

  logic          clk_72;
  logic          reset;
  logic          ioctl_downl;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic [3:0]    pcb;
  logic          tate;
  logic [7:0]    brd;
  logic          wr_req;
  logic          wr_ack;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [1:0]    wr_be;
  logic          rom_loaded;
  logic          busy;
  logic          overflow;
  logic [15:0]   csum;
  logic [1:0]    dbg_state;

  int tests_run;
  int tests_failed;
  logic [EW-1:0] exp_q[$];

  rom_dl_sched #(.HDR_BYTES(2), .AW(AW), .FIFO_DEPTH(4)) dut (
    .clk_72     (clk_72),
    .reset      (reset),
    .ioctl_downl(ioctl_downl),
    .ioctl_wr   (ioctl_wr),
    .ioctl_addr (ioctl_addr),
    .ioctl_dout (ioctl_dout),
    .pcb        (pcb),
    .tate       (tate),
    .brd        (brd),
    .wr_req     (wr_req),
    .wr_ack     (wr_ack),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_be      (wr_be),
    .rom_loaded (rom_loaded),
    .busy       (busy),
    .overflow   (overflow),
    .csum       (csum),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk_72 = 1'b0;
  always #7 clk_72 = ~clk_72;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk_72);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_downl(input logic v);
    ioctl_downl = v;
    tick();
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  function automatic logic [EW-1:0] mk(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] be);
    return {a, d, be};
  endfunction

  // scoreboard: serve n writes, ack each dly cycles after its request is seen
  task automatic serve(input int n, input int dly);
    logic [EW-1:0] e;
    logic [15:0] mask;
    for (int k = 0; k < n; k++) begin
      int budget = 0;
      while (!wr_req && budget < 64) begin
        tick();
        budget++;
      end
      check("wr_req_seen", wr_req, 1'b1);
      if (wr_req) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_write", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          mask = {{8{e[1]}}, {8{e[0]}}};
          check("wr_addr", wr_addr, e[EW-1:18]);
          check("wr_be", wr_be, e[1:0]);
          check("wr_data", wr_data & mask, e[17:2] & mask);
          repeat (dly) tick();
          check("wr_hold", {wr_addr, wr_data & mask, wr_be}, {e[EW-1:18], e[17:2] & mask, e[1:0]});
        end
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    ioctl_downl = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    wr_ack = 1'b0;
    do_reset();

    // reset state
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_outputs", {pcb, tate, brd, wr_req, rom_loaded, busy, overflow, csum},
          '0);

    // 1: header bytes
    set_downl(1'b1);
    check("t1_state_load", dbg_state, ST_LOAD);
    check("t1_busy", busy, 1'b1);
    wr_byte(25'd0, 8'h83);
    wr_byte(25'd1, 8'h5A);
    check("t1_tate", tate, 1'b1);
    check("t1_pcb", pcb, 4'h3);
    check("t1_brd", brd, 8'h5A);
    check("t1_no_req", wr_req, 1'b0);

    // 2: four payload bytes, acks 2 cycles after each request
    wr_byte(25'd2, 8'h11);
    check("t2_half_no_req", wr_req, 1'b0);
    wr_byte(25'd3, 8'h22);
    check("t2_push_latency", {wr_req, wr_data}, {1'b1, 16'h2211});
    wr_byte(25'd4, 8'h33);
    wr_byte(25'd5, 8'h44);
    exp_q.push_back(mk(23'd0, 16'h2211, 2'b11));
    exp_q.push_back(mk(23'd1, 16'h4433, 2'b11));
    set_downl(1'b0);
    check("t2_state_flush", dbg_state, ST_FLUSH);
    check("t2_not_loaded", rom_loaded, 1'b0);
    serve(2, 2);
    tick();
    tick();
    check("t2_state_done", dbg_state, ST_DONE);
    check("t2_rom_loaded", rom_loaded, 1'b1);
    check("t2_busy_low", busy, 1'b0);
`ifdef DL_CHECKSUM_EN
    check("t2_csum", csum, 16'h00AA);
`else
    check("t2_csum", csum, 16'h0000);
`endif

    // 3: odd payload count, trailing half-word written on flush
    set_downl(1'b1);
    check("t3_reload_clears", {rom_loaded, dbg_state}, {1'b0, ST_LOAD});
    check("t3_hdr_kept", {tate, pcb, brd}, {1'b1, 4'h3, 8'h5A});
    wr_byte(25'd2, 8'hAA);
    wr_byte(25'd3, 8'hBB);
    wr_byte(25'd4, 8'hCC);
    exp_q.push_back(mk(23'd0, 16'hBBAA, 2'b11));
    exp_q.push_back(mk(23'd1, 16'h00CC, 2'b01));
    set_downl(1'b0);
    serve(2, 0);
    tick();
    tick();
    check("t3_done", {dbg_state, rom_loaded, wr_req}, {ST_DONE, 1'b1, 1'b0});

    // 4: no acks, five words into a four-entry FIFO
    set_downl(1'b1);
    for (int i = 0; i < 8; i++) wr_byte(25'(2 + i), 8'(8'h10 + i));
    check("t4_full_no_ovf", overflow, 1'b0);
    check("t4_head", {wr_req, wr_addr, wr_data}, {1'b1, 23'd0, 16'h1110});
    wr_byte(25'd10, 8'h18);
    wr_byte(25'd11, 8'h19);
    check("t4_overflow", overflow, 1'b1);
    for (int k = 0; k < 4; k++)
      exp_q.push_back(mk(23'(k), {8'(8'h11 + 2 * k), 8'(8'h10 + 2 * k)}, 2'b11));
    set_downl(1'b0);
    serve(4, 1);
    tick();
    tick();
    check("t4_drained", {wr_req, dbg_state, rom_loaded}, {1'b0, ST_DONE, 1'b1});
    check("t4_ovf_sticky", overflow, 1'b1);
    wr_byte(25'd2, 8'h77);
    check("t4_ignored_in_done", {wr_req, dbg_state}, {1'b0, ST_DONE});

    // 5: reset mid-LOAD with two entries queued
    set_downl(1'b1);
    check("t5_ovf_cleared", overflow, 1'b0);
    wr_byte(25'd2, 8'h01);
    wr_byte(25'd3, 8'h02);
    wr_byte(25'd4, 8'h03);
    wr_byte(25'd5, 8'h04);
    check("t5_queued", wr_req, 1'b1);
    reset = 1'b1;
    tick();
    check("t5_reset_abort", {wr_req, rom_loaded, dbg_state, pcb, brd}, '0);
    reset = 1'b0;
    ioctl_downl = 1'b0;
    tick();

    // 6: checksum and out-of-range address
    set_downl(1'b1);
    wr_byte(25'h1FF_FFFF, 8'h55);
    check("t6_oor_ignored", {wr_req, overflow}, 2'b00);
    wr_byte(25'd2, 8'hFF);
    wr_byte(25'd3, 8'hFF);
    wr_byte(25'd4, 8'h02);
`ifdef DL_CHECKSUM_EN
    check("t6_csum_load", csum, 16'h0200);
`else
    check("t6_csum_load", csum, 16'h0000);
`endif
    exp_q.push_back(mk(23'd0, 16'hFFFF, 2'b11));
    exp_q.push_back(mk(23'd1, 16'h0002, 2'b01));
    set_downl(1'b0);
    serve(2, 1);
    tick();
    tick();
    check("t6_done", {dbg_state, rom_loaded}, {ST_DONE, 1'b1});
`ifdef DL_CHECKSUM_EN
    check("t6_csum_done", csum, 16'h0200);
`else
    check("t6_csum_done", csum, 16'h0000);
`endif

    check("sb_empty", exp_q.size(), 0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
